// File: rtl/layer_serializer.sv
// rtl/layer_serializer.sv - parallel-vector to serial-word transmitter
//
// Accepts one INPUT_SIZE-word vector per upstream handshake. It then emits the
// words one per downstream handshake, element 0 first.
//
// Ports:
//   clk_i     clock, all state updates on the rising edge
//   reset_i   synchronous active-high reset
//   ready_o   upstream: a vector can be accepted this cycle
//   valid_i   upstream: data_i holds a valid vector
//   data_i    upstream vector, element 0 is sent first
//   valid_o   downstream: data_r_o holds a valid word
//   ready_i   downstream: next layer takes the word this cycle
//   data_r_o  current word, straight from the buffer register
//   last_o    current word is element INPUT_SIZE-1
module layer_serializer #(
  parameter int INPUT_SIZE = 4,
  parameter int WORD_SIZE  = 16
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  output logic                                      ready_o,
  input  logic                                      valid_i,
  input  logic signed [INPUT_SIZE-1:0][WORD_SIZE-1:0] data_i,
  output logic                                      valid_o,
  input  logic                                      ready_i,
  output logic signed [WORD_SIZE-1:0]               data_r_o,
  output logic                                      last_o
);

  localparam int CW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(INPUT_SIZE - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                              state;
  logic [INPUT_SIZE-1:0][WORD_SIZE-1:0] buf_r;
  logic [CW-1:0]                       count_r;
  logic                                accept;
  logic                                emit;

  assign valid_o  = (state == SEND);
  assign last_o   = valid_o && (count_r == LAST_IDX);
  assign data_r_o = buf_r[0];

  // The final word and the next vector may transfer in the same cycle, so
  // ready_o follows ready_i combinationally while the last word is shown.
  assign ready_o = !reset_i && ((state == IDLE) || (last_o && ready_i));
  assign accept  = valid_i && ready_o;
  assign emit    = valid_o && ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      count_r <= '0;
      buf_r   <= '0;
    end else if (accept) begin
      // In SEND an accept implies the last word is leaving, so a reload
      // covers both the IDLE entry and the back-to-back case.
      buf_r   <= data_i;
      count_r <= '0;
      state   <= SEND;
    end else if (emit) begin
      for (int i = 0; i < INPUT_SIZE - 1; i++) begin
        buf_r[i] <= buf_r[i+1];
      end
      buf_r[INPUT_SIZE-1] <= '0;
      if (last_o) begin
        count_r <= '0;
        state   <= IDLE;
      end else begin
        count_r <= count_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// tb/tb_layer_serializer.sv - directed self-checking bench for layer_serializer
module tb_layer_serializer;

  logic                     clk_i = 1'b0;
  logic                     reset_i;
  logic                     ready_o;
  logic                     valid_i;
  logic signed [3:0][15:0]  data_i;
  logic                     valid_o;
  logic                     ready_i;
  logic signed [15:0]       data_r_o;
  logic                     last_o;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [3:0][15:0] V1 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [3:0][15:0] V2 = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
  localparam logic [3:0][15:0] V3 = {16'h0040, 16'h0030, 16'h0020, 16'h0010};

  layer_serializer #(.INPUT_SIZE(4), .WORD_SIZE(16)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .ready_o  (ready_o),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_r_o (data_r_o),
    .last_o   (last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] d, input logic v,
                            input logic l, input logic r);
    #1;
    chk({tag, ".data"},  {16'h0, data_r_o}, {16'h0, d});
    chk({tag, ".valid"}, {31'h0, valid_o},  {31'h0, v});
    chk({tag, ".last"},  {31'h0, last_o},   {31'h0, l});
    chk({tag, ".ready"}, {31'h0, ready_o},  {31'h0, r});
  endtask

  initial begin
    // reset held two cycles with a valid vector on the input
    reset_i = 1'b1; valid_i = 1'b1; data_i = V1; ready_i = 1'b1;
    tick(); expect_out("rst0", 16'h0000, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("rst1", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset_i = 1'b0; valid_i = 1'b0;
    expect_out("rel0", 16'h0000, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("rel1", 16'h0000, 1'b0, 1'b0, 1'b1);

    // basic stream
    valid_i = 1'b1; data_i = V1;
    tick(); valid_i = 1'b0;
    expect_out("bs0", 16'h0001, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("bs1", 16'h0002, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("bs2", 16'h0003, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("bs3", 16'h0004, 1'b1, 1'b1, 1'b1);
    tick(); #1;
    chk("bs_idle.valid", {31'h0, valid_o}, 32'h0);
    chk("bs_idle.ready", {31'h0, ready_o}, 32'h1);

    // backpressure with a stalled next vector, then back-to-back
    valid_i = 1'b1; data_i = V1;
    tick(); valid_i = 1'b0;
    expect_out("bp0", 16'h0001, 1'b1, 1'b0, 1'b0);
    tick();
    ready_i = 1'b0; valid_i = 1'b1; data_i = V2;
    expect_out("bp1", 16'h0002, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out($sformatf("bp_hold%0d", i), 16'h0002, 1'b1, 1'b0, 1'b0);
    end
    ready_i = 1'b1;
    expect_out("bp_resume", 16'h0002, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("bp2", 16'h0003, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("bp3", 16'h0004, 1'b1, 1'b1, 1'b1);
    tick(); valid_i = 1'b0;
    expect_out("b2b0", 16'h0005, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("b2b1", 16'h0006, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("b2b2", 16'h0007, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("b2b3", 16'h0008, 1'b1, 1'b1, 1'b1);
    tick(); #1;
    chk("b2b_idle.valid", {31'h0, valid_o}, 32'h0);

    // reset while 0x0002 is on the output
    valid_i = 1'b1; data_i = V1;
    tick(); valid_i = 1'b0;
    expect_out("rm0", 16'h0001, 1'b1, 1'b0, 1'b0);
    tick(); reset_i = 1'b1;
    expect_out("rm1", 16'h0002, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("rm_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset_i = 1'b0; valid_i = 1'b1; data_i = V3;
    tick(); valid_i = 1'b0;
    expect_out("rm_n0", 16'h0010, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("rm_n1", 16'h0020, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("rm_n2", 16'h0030, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("rm_n3", 16'h0040, 1'b1, 1'b1, 1'b1);
    tick(); #1;
    chk("rm_idle.valid", {31'h0, valid_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
